triangle_sequencer: RTL and testbench

- Controller that sequences a triangle-wave generator datapath (N-bit up/down counter with clear and enable inputs).
- Issues a one-cycle clear, then paced enable strobes at a programmable rate for a programmed number of full triangle periods.
- Reports busy, periods completed and a completion pulse.
- Sits between the control/CSR logic and the generator, which owns the waveform value.

---
 rtl/triangle_sequencer.sv | 88 ++++++++
 tb/tb_triangle_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_sequencer.sv
// triangle_sequencer: paces clear/enable strobes for a triangle-wave generator over N full periods
module triangle_sequencer #(
    parameter int N     = 8,
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [DIV_W-1:0] step_div,
    input  logic [CNT_W-1:0] num_periods,
    output logic             gen_clr,
    output logic             gen_ena,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] periods_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    // last step index of a period: 2*(2^N-1)-1 = 2^(N+1)-3
    localparam logic [N:0] LAST_STEP = {{(N-1){1'b1}}, 2'b01};

    logic [1:0]       state;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] num_q;
    logic [N:0]       step_cnt;
    logic             running;
    logic             last_step;
    logic             final_step;
    logic             accept;
    logic             empty_req;

    assign accept     = state == IDLE && start && num_periods != '0;
    assign empty_req  = state == IDLE && start && num_periods == '0;
    assign running    = state == RUN && !abort;
    assign gen_ena    = running && !pause && presc == div_q;
    assign gen_clr    = state == CLEAR;
    assign busy       = state != IDLE;
    assign last_step  = gen_ena && step_cnt == LAST_STEP;
    assign final_step = last_step && periods_done + 1'b1 == num_q;

    // control FSM: abort beats completion, start only honoured in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= accept ? CLEAR :
                     state == CLEAR ? (abort ? IDLE : RUN) :
                     (state == RUN && (abort || final_step)) ? IDLE : state;
    end

    // run parameters are frozen at acceptance so CSR edits mid-run are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            num_q <= '0;
        end else if (accept) begin
            div_q <= step_div;
            num_q <= num_periods;
        end
    end

    // prescaler and step position; both freeze while paused or aborting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            step_cnt <= '0;
        end else begin
            presc    <= state == CLEAR ? '0 : (running && !pause) ? (gen_ena ? '0 : presc + 1'b1) : presc;
            step_cnt <= state == CLEAR ? '0 : gen_ena ? (last_step ? '0 : step_cnt + 1'b1) : step_cnt;
        end
    end

    // period tally and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            periods_done <= '0;
            done         <= 1'b0;
        end else begin
            periods_done <= (state == IDLE && start) ? '0 : last_step ? periods_done + 1'b1 : periods_done;
            done         <= empty_req || final_step;
        end
    end
endmodule

// File: tb/tb_triangle_sequencer.sv
// tb_triangle_sequencer: scoreboard bench for triangle_sequencer with N=3 (P=14)
module tb_triangle_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic [15:0] step_div = '0;
    logic [7:0]  num_periods = '0;
    logic        gen_clr, gen_ena, busy, done;
    logic [7:0]  periods_done;

    triangle_sequencer #(.N(3), .DIV_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .step_div(step_div), .num_periods(num_periods),
        .gen_clr(gen_clr), .gen_ena(gen_ena), .busy(busy), .done(done),
        .periods_done(periods_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int pd;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  passes = 0;
    int  ena_cnt = 0;
    int  ena_paused = 0;
    int  busy_cnt = 0;
    int  ena_base = 0;
    int  first_ena = 0;
    int  last_ena = 0;
    int  pd_at14 = -1;
    bit  prev_ena = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input int kind, input int c, input int pd);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.pd   = pd;
        q.push_back(e);
    endtask

    // monitor: pops an expectation whenever the DUT presents gen_clr or done
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst) begin
            if (prev_ena && ena_cnt - ena_base == 14) pd_at14 = int'(periods_done);
            prev_ena = gen_ena;
            if (gen_ena) begin
                ena_cnt++;
                if (ena_cnt - ena_base == 1) first_ena = cyc;
                last_ena = cyc;
                if (pause) ena_paused++;
            end
            if (busy) busy_cnt++;
            if (gen_clr || done) begin
                if (q.size() == 0) begin
                    check("unexpected_event", int'({gen_clr, done}), 0);
                end else begin
                    e = q.pop_front();
                    check("event_kind", done ? 1 : 0, e.kind);
                    check("event_cycle", cyc, e.cyc);
                    if (done) begin
                        check("done_periods", int'(periods_done), e.pd);
                        check("done_busy", int'(busy), 0);
                    end
                end
            end
        end
    end

    task automatic start_run(input int div, input int n, input int done_off, input int pd,
                             input bit clr, output int t);
        @(posedge clk);
        #1;
        step_div    = div[15:0];
        num_periods = n[7:0];
        start       = 1'b1;
        t           = cyc;
        if (clr) push_ev(0, t + 1, 0);
        if (done_off > 0) push_ev(1, t + done_off, pd);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int b;
        int p;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_clr", int'(gen_clr), 0);
        check("rst_ena", int'(gen_ena), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pd", int'(periods_done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // div=0, one period: 14 back-to-back strobes, done at t+16
        ena_base = ena_cnt;
        start_run(0, 1, 16, 1, 1'b1, t);
        drain(100);
        check("d0_count", ena_cnt - ena_base, 14);
        check("d0_first", first_ena - t, 2);
        check("d0_last", last_ena - t, 15);

        // div=3, two periods: strobe every 4th cycle, 28 total
        ena_base = ena_cnt;
        start_run(3, 2, 114, 2, 1'b1, t);
        drain(300);
        check("d3_count", ena_cnt - ena_base, 28);
        check("d3_first", first_ena - t, 5);
        check("d3_span", last_ena - first_ena, 108);
        check("d3_pd_after14", pd_at14, 1);

        // div=1 with 5 paused cycles: done slips from t+30 to t+35
        ena_base = ena_cnt;
        p = ena_paused;
        start_run(1, 1, 35, 1, 1'b1, t);
        wait_cyc(t + 10);
        pause = 1'b1;
        wait_cyc(t + 15);
        pause = 1'b0;
        drain(100);
        check("pause_count", ena_cnt - ena_base, 14);
        check("pause_ena", ena_paused - p, 0);

        // zero periods: done next cycle, nothing else
        ena_base = ena_cnt;
        b = busy_cnt;
        start_run(5, 0, 1, 0, 1'b0, t);
        drain(20);
        check("zero_ena", ena_cnt - ena_base, 0);
        check("zero_busy", busy_cnt - b, 0);

        // abort on the final strobe: suppressed, no increment, no done
        ena_base = ena_cnt;
        start_run(0, 1, 0, 0, 1'b1, t);
        wait_cyc(t + 15);
        abort = 1'b1;
        #1;
        check("abort_ena", int'(gen_ena), 0);
        check("abort_busy_pre", int'(busy), 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_pd", int'(periods_done), 0);
        check("abort_count", ena_cnt - ena_base, 13);
        drain(20);

        // restart after abort, with a start pulse while busy that must be ignored
        ena_base = ena_cnt;
        start_run(0, 1, 16, 1, 1'b1, t);
        wait_cyc(t + 5);
        step_div    = 16'd5;
        num_periods = 8'd3;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(100);
        check("busy_start_count", ena_cnt - ena_base, 14);

        // asynchronous reset mid-run
        start_run(2, 3, 0, 0, 1'b1, t);
        wait_cyc(t + 50);
        check("pre_rst_pd", int'(periods_done), 1);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ena", int'(gen_ena), 0);
        check("mid_rst_clr", int'(gen_clr), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_pd", int'(periods_done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("final_queue", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
